scu_dsp_dma_ctrl: RTL and testbench

- External-bus side of the SCU DSP's D0 DMA port; sits directly downstream of the SCU DSP core.
- Captures the RA0/WA0 address registers and the DMA instruction word the DSP broadcasts on its DSO bus.
- Serves each DSP word request with one external bus access, handing the read data back or writing the DSP's outgoing data.
- Signals completion to the DSP with an END pulse, whose falling edge the DSP uses to release T0.

---
 rtl/scu_dsp_dma_ctrl_pkg.sv | 32 +++
 rtl/scu_dsp_dma_ctrl.sv | 134 +++++++++++++
 tb/tb_scu_dsp_dma_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scu_dsp_dma_ctrl_pkg.sv
// Shared types and helpers for the SCU DSP D0 DMA controller.
// Covers the FSM states, the latched DMA command fields and the address step rule.
package scu_dsp_dma_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    BUS  = 3'd2,
    ACK  = 3'd3,
    END  = 3'd4,
    DONE = 3'd5
  } DMAState_t;

  typedef struct packed {
    logic       dir;   // 1 = DSP RAM to bus
    logic       hold;  // 1 = no address write-back
    logic [2:0] add;
  } DMACmd_t;

  localparam int DSO_DIR_BIT  = 12;
  localparam int DSO_HOLD_BIT = 14;
  localparam int DSO_ADD_LSB  = 15;
  localparam int DSO_ADD_MSB  = 17;

  // Reads always step one word whenever any increment is requested.
  function automatic logic [8:0] DmaInc(input logic [2:0] add, input logic dir);
    if (add == 3'd0) return 9'd0;
    if (!dir)        return 9'd4;
    return 9'd4 << (add - 3'd1);
  endfunction

endpackage

// File: rtl/scu_dsp_dma_ctrl.sv
// External-bus side of the SCU DSP D0 DMA port: one bus access per DSP word request,
// RA0/WA0 address tracking and an END pulse on completion or bus timeout.
module scu_dsp_dma_ctrl
  import scu_dsp_dma_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 27,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE,
  input  logic [31:0]       DSO,
  input  logic              RA0W,
  input  logic              WA0W,
  input  logic              DMAW,
  input  logic              DMA_REQ,
  input  logic              DMA_WE,
  input  logic [31:0]       DMA_DO,
  input  logic              DMA_LAST,
  output logic [31:0]       DMA_DI,
  output logic              DMA_ACK,
  output logic              DMA_END,
  output logic [ADDR_W-1:0] BUS_A,
  output logic [31:0]       BUS_DO,
  input  logic [31:0]       BUS_DI,
  output logic              BUS_REQ,
  output logic              BUS_WE,
  input  logic              BUS_RDY,
  output logic              BUSY
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  DMAState_t         state, nxt;
  DMACmd_t           cmd;
  logic [ADDR_W-1:0] ra0, wa0, ptr;
  logic [ADDR_W-1:0] dso_addr;
  logic [TW-1:0]     tmo_cnt;
  logic              lastf, aborted;
  logic [31:0]       di;
  logic              tmo_hit, wb;

  // Direction comes from the latched instruction, so DMA_WE and the top DSO bits are not needed.
  logic unused;
  assign unused = &{1'b0, DMA_WE, DSO[31:25]};

  assign dso_addr = ADDR_W'({DSO[24:0], 2'b00});
  assign tmo_hit  = (TIMEOUT != 0) && (tmo_cnt == TW'(TIMEOUT - 1));
  assign wb       = (state == END) && !cmd.hold && !aborted;
  assign DMA_DI   = di;

  always_ff @(posedge CLK) begin
    if (RST)     state <= IDLE;
    else if (CE) state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (DMAW) nxt = WAIT;
      WAIT:    if (DMA_REQ) nxt = BUS;
      BUS: begin
        if (BUS_RDY)      nxt = ACK;
        else if (tmo_hit) nxt = END;
      end
      ACK:     nxt = lastf ? END : WAIT;
      END:     nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    BUS_REQ = 1'b0;
    BUS_WE  = 1'b0;
    BUS_A   = '0;
    BUS_DO  = '0;
    DMA_ACK = 1'b0;
    DMA_END = 1'b0;
    BUSY    = (state != IDLE) && (state != DONE);
    case (state)
      BUS: begin
        BUS_REQ = 1'b1;
        BUS_WE  = cmd.dir;
        BUS_A   = ptr;
        BUS_DO  = DMA_DO;
      end
      ACK:     DMA_ACK = 1'b1;
      END:     DMA_END = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ra0     <= '0;
      wa0     <= '0;
      ptr     <= '0;
      cmd     <= '0;
      lastf   <= 1'b0;
      aborted <= 1'b0;
      tmo_cnt <= '0;
      di      <= '0;
    end else if (CE) begin
      // A register load from the DSP in the write-back cycle overrides the write-back.
      if (RA0W)                ra0 <= dso_addr;
      else if (wb && !cmd.dir) ra0 <= ptr;
      if (WA0W)                wa0 <= dso_addr;
      else if (wb && cmd.dir)  wa0 <= ptr;

      case (state)
        IDLE: if (DMAW) begin
          cmd.dir  <= DSO[DSO_DIR_BIT];
          cmd.hold <= DSO[DSO_HOLD_BIT];
          cmd.add  <= DSO[DSO_ADD_MSB:DSO_ADD_LSB];
          ptr      <= DSO[DSO_DIR_BIT] ? wa0 : ra0;
          aborted  <= 1'b0;
        end
        WAIT: if (DMA_REQ) begin
          lastf   <= DMA_LAST;
          tmo_cnt <= '0;
        end
        BUS: begin
          if (BUS_RDY)      di      <= BUS_DI;
          else if (tmo_hit) aborted <= 1'b1;
          else              tmo_cnt <= tmo_cnt + 1'b1;
        end
        ACK:     ptr <= ptr + ADDR_W'(DmaInc(cmd.add, cmd.dir));
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scu_dsp_dma_ctrl.sv
// Directed bench for scu_dsp_dma_ctrl: bus accesses and DSP read data are scoreboarded.
module tb_scu_dsp_dma_ctrl;
  import scu_dsp_dma_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        RST, CE, RA0W, WA0W, DMAW, DMA_REQ, DMA_WE, DMA_LAST, BUS_RDY;
  logic [31:0] DSO, DMA_DO, BUS_DI;
  logic [31:0] DMA_DI, BUS_DO;
  logic [26:0] BUS_A;
  logic        DMA_ACK, DMA_END, BUS_REQ, BUS_WE, BUSY;

  scu_dsp_dma_ctrl #(.ADDR_W(27), .TIMEOUT(8)) dut (
    .CLK(clk), .RST(RST), .CE(CE), .DSO(DSO), .RA0W(RA0W), .WA0W(WA0W), .DMAW(DMAW),
    .DMA_REQ(DMA_REQ), .DMA_WE(DMA_WE), .DMA_DO(DMA_DO), .DMA_LAST(DMA_LAST),
    .DMA_DI(DMA_DI), .DMA_ACK(DMA_ACK), .DMA_END(DMA_END), .BUS_A(BUS_A), .BUS_DO(BUS_DO),
    .BUS_DI(BUS_DI), .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_RDY(BUS_RDY), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  typedef struct { logic [26:0] a; logic we; logic [31:0] d; } bus_exp_t;

  bus_exp_t    exp_bus[$];
  logic [31:0] exp_di[$];
  logic [31:0] rdq[$];
  bus_exp_t    mon_e;
  int n_chk = 0, n_fail = 0;
  int ack_cnt = 0, end_cnt = 0;
  int rdy_delay = 0, wcnt = 0;
  logic stuck = 1'b0;
  logic prev_req = 1'b0, prev_ack = 1'b0, prev_end = 1'b0;
  logic [26:0] ra0_m, wa0_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus slave: answers after rdy_delay wait cycles unless stuck.
  always @(negedge clk) begin
    if (BUS_REQ && !stuck) begin
      if (wcnt >= rdy_delay) begin
        BUS_RDY = 1'b1;
        BUS_DI  = (rdq.size() > 0) ? rdq.pop_front() : 32'hDEAD_BEEF;
      end else begin
        BUS_RDY = 1'b0;
        wcnt++;
      end
    end else begin
      BUS_RDY = 1'b0;
      wcnt    = 0;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (BUS_REQ && !prev_req) begin
      chk("bus_exp_avail", 32'(exp_bus.size() > 0), 32'd1);
      if (exp_bus.size() > 0) begin
        mon_e = exp_bus.pop_front();
        chk("bus_a", 32'(BUS_A), 32'(mon_e.a));
        chk("bus_we", 32'(BUS_WE), 32'(mon_e.we));
        chk("bus_do", BUS_DO, mon_e.d);
      end
    end
    if (DMA_ACK) begin
      ack_cnt++;
      chk("ack_pulse", 32'(prev_ack), 32'd0);
      chk("di_exp_avail", 32'(exp_di.size() > 0), 32'd1);
      if (exp_di.size() > 0) chk("dma_di", DMA_DI, exp_di.pop_front());
    end
    if (DMA_END) begin
      end_cnt++;
      chk("end_pulse", 32'(prev_end), 32'd0);
    end
    prev_req = BUS_REQ;
    prev_ack = DMA_ACK;
    prev_end = DMA_END;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_reg(input logic wa, input logic [31:0] v);
    @(negedge clk);
    DSO = v; RA0W = !wa; WA0W = wa;
    @(negedge clk);
    RA0W = 1'b0; WA0W = 1'b0;
    if (wa) wa0_m = {v[24:0], 2'b00};
    else    ra0_m = {v[24:0], 2'b00};
  endtask

  task automatic start(input logic dir, input logic hold, input logic [2:0] add);
    logic [31:0] v;
    v = '0;
    v[DSO_DIR_BIT] = dir;
    v[DSO_HOLD_BIT] = hold;
    v[DSO_ADD_MSB:DSO_ADD_LSB] = add;
    @(negedge clk);
    DSO = v; DMAW = 1'b1; DMA_WE = dir;
    @(negedge clk);
    DMAW = 1'b0;
  endtask

  // One word: queue expectations, request, count BUS_REQ cycles until it drops.
  task automatic xword(input logic [26:0] a, input logic we, input logic [31:0] d,
                       input logic [31:0] rd, input logic last, input logic expect_ack,
                       output int run);
    exp_bus.push_back('{a: a, we: we, d: d});
    if (expect_ack) exp_di.push_back(we ? 32'hDEAD_BEEF : rd);
    if (!we && expect_ack) rdq.push_back(rd);
    @(negedge clk);
    DMA_DO = d; DMA_LAST = last; DMA_REQ = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (BUS_REQ) break;
    end
    DMA_REQ = 1'b0;
    chk("bus_req_start", 32'(BUS_REQ), 32'd1);
    run = 0;
    for (int k = 0; k < 40 && BUS_REQ; k++) begin
      run++;
      @(negedge clk);
    end
  endtask

  task automatic finish_xfer();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!BUSY) break;
    end
    chk("busy_drop", 32'(BUSY), 32'd0);
  endtask

  initial begin
    int run, a0, e0;
    RST = 1'b1; CE = 1'b1; DSO = '0; RA0W = 0; WA0W = 0; DMAW = 0;
    DMA_REQ = 0; DMA_WE = 0; DMA_DO = '0; DMA_LAST = 0; BUS_RDY = 0; BUS_DI = '0;
    ra0_m = '0; wa0_m = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'({BUS_REQ, BUS_WE, DMA_ACK, DMA_END, BUSY}), 32'd0);
    chk("rst_bus_a", 32'(BUS_A), 32'd0);
    chk("rst_di", DMA_DI, 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_ra0", 32'(dut.ra0), 32'd0);
    RST = 1'b0;

    // Basic read, 4 words at stride 4.
    load_reg(1'b0, 32'h100);
    a0 = ack_cnt; e0 = end_cnt;
    start(1'b0, 1'b0, 3'd1);
    for (int i = 0; i < 4; i++) begin
      xword(27'h400 + 27'(4 * i), 1'b0, 32'h5500 + 32'(i), 32'hA0 + 32'(i), i == 3, 1'b1, run);
      chk("rd_run", 32'(run), 32'd1);
    end
    finish_xfer();
    ra0_m = 27'h410;
    chk("rd_ra0", 32'(dut.ra0), 32'(ra0_m));
    chk("rd_acks", 32'(ack_cnt - a0), 32'd4);
    chk("rd_ends", 32'(end_cnt - e0), 32'd1);

    // Write with 16-byte stride, CE stall in WAIT between words.
    load_reg(1'b1, 32'h80);
    start(1'b1, 1'b0, 3'd3);
    xword(27'h200, 1'b1, 32'h1111_1111, 32'h0, 1'b0, 1'b1, run);
    @(negedge clk);
    CE = 1'b0; DMA_REQ = 1'b1;
    repeat (3) @(negedge clk);
    chk("ce_hold_req", 32'(BUS_REQ), 32'd0);
    chk("ce_hold_state", 32'(dut.state), 32'(WAIT));
    CE = 1'b1; DMA_REQ = 1'b0;
    xword(27'h210, 1'b1, 32'h2222_2222, 32'h0, 1'b1, 1'b1, run);
    finish_xfer();
    wa0_m = 27'h220;
    chk("wr_wa0", 32'(dut.wa0), 32'(wa0_m));
    chk("wr_ra0_kept", 32'(dut.ra0), 32'(ra0_m));

    // HOLD: RA0 keeps its start value.
    load_reg(1'b0, 32'h100);
    start(1'b0, 1'b1, 3'd1);
    for (int i = 0; i < 4; i++)
      xword(27'h400 + 27'(4 * i), 1'b0, 32'h0, 32'hB0 + 32'(i), i == 3, 1'b1, run);
    finish_xfer();
    chk("hold_ra0", 32'(dut.ra0), 32'h400);

    // Wait states; read with ADD=2 still steps by 4.
    rdy_delay = 5;
    a0 = ack_cnt;
    start(1'b0, 1'b0, 3'd2);
    for (int i = 0; i < 3; i++) begin
      xword(27'h400 + 27'(4 * i), 1'b0, 32'h0, 32'hC0 + 32'(i), i == 2, 1'b1, run);
      chk("ws_run", 32'(run), 32'd6);
    end
    finish_xfer();
    rdy_delay = 0;
    chk("ws_acks", 32'(ack_cnt - a0), 32'd3);
    chk("ws_ra0", 32'(dut.ra0), 32'h40C);

    // Address wrap at the top of the bus.
    load_reg(1'b0, 32'h01FF_FFFF);
    start(1'b0, 1'b0, 3'd1);
    xword(27'h7FF_FFFC, 1'b0, 32'h0, 32'hD0, 1'b0, 1'b1, run);
    xword(27'h000_0000, 1'b0, 32'h0, 32'hD1, 1'b1, 1'b1, run);
    finish_xfer();
    chk("wrap_ra0", 32'(dut.ra0), 32'h4);

    // RA0W coincident with the END write-back wins.
    start(1'b0, 1'b0, 3'd1);
    xword(27'h4, 1'b0, 32'h0, 32'hE0, 1'b1, 1'b1, run);
    @(negedge clk);
    chk("coinc_end", 32'(DMA_END), 32'd1);
    DSO = 32'h300; RA0W = 1'b1;
    @(negedge clk);
    RA0W = 1'b0;
    finish_xfer();
    chk("coinc_ra0", 32'(dut.ra0), 32'hC00);

    // Reset in BUS.
    stuck = 1'b1;
    e0 = end_cnt;
    start(1'b0, 1'b0, 3'd1);
    exp_bus.push_back('{a: 27'hC00, we: 1'b0, d: 32'h77});
    @(negedge clk);
    DMA_DO = 32'h77; DMA_LAST = 1'b1; DMA_REQ = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (BUS_REQ) break;
    end
    DMA_REQ = 1'b0;
    chk("rstbus_in_bus", 32'(BUS_REQ), 32'd1);
    RST = 1'b1;
    @(negedge clk);
    chk("rstbus_ctrl", 32'({BUS_REQ, BUS_WE, DMA_ACK, DMA_END, BUSY}), 32'd0);
    chk("rstbus_a", 32'(BUS_A), 32'd0);
    chk("rstbus_do", BUS_DO, 32'd0);
    chk("rstbus_di", DMA_DI, 32'd0);
    chk("rstbus_state", 32'(dut.state), 32'(IDLE));
    RST = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstbus_no_end", 32'(end_cnt - e0), 32'd0);
    stuck = 1'b0;

    // Timeout with BUS_RDY stuck low.
    load_reg(1'b0, 32'h100);
    stuck = 1'b1;
    a0 = ack_cnt; e0 = end_cnt;
    start(1'b0, 1'b0, 3'd1);
    xword(27'h400, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, run);
    chk("tmo_run", 32'(run), 32'd8);
    chk("tmo_end", 32'(DMA_END), 32'd1);
    finish_xfer();
    stuck = 1'b0;
    chk("tmo_acks", 32'(ack_cnt - a0), 32'd0);
    chk("tmo_ends", 32'(end_cnt - e0), 32'd1);
    chk("tmo_ra0", 32'(dut.ra0), 32'h400);
    chk("sb_bus_empty", 32'(exp_bus.size()), 32'd0);
    chk("sb_di_empty", 32'(exp_di.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
